// File: rtl/id_mem_arbiter.sv
// id_mem_arbiter: lets the instruction-side (I) and data-side (D) ports share
// one memory port (M). D has priority, I is protected from starvation by a
// D-grant streak counter, and a grant is held for the whole burst.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; M request side parked at 0; arbitrate sampled IREQ/DREQ
// GNT_I | I master owns M until its last beat or it drops IREQ
// GNT_D | D master owns M until its last beat or it drops DREQ
module id_mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int BURST_LEN    = 4,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  // I master
  input  logic [AW-1:0]     IADDR,
  input  logic [1:0]        IBURST,
  input  logic              IREQ,
  input  logic              IWRB,
  input  logic [DW-1:0]     IWDATA,
  input  logic [DW/8-1:0]   IBSTROBE,
  output logic [DW-1:0]     IRDATA,
  output logic              IACK,
  output logic              ISTALL,
  // D master
  input  logic [AW-1:0]     DADDR,
  input  logic [1:0]        DBURST,
  input  logic              DREQ,
  input  logic              DWRB,
  input  logic [DW-1:0]     DWDATA,
  input  logic [DW/8-1:0]   DBSTROBE,
  output logic [DW-1:0]     DRDATA,
  output logic              DACK,
  output logic              DSTALL,
  // memory slave
  output logic [AW-1:0]     MADDR,
  output logic [1:0]        MBURST,
  output logic              MREQ,
  output logic              MWRB,
  output logic [DW-1:0]     MWDATA,
  output logic [DW/8-1:0]   MBSTROBE,
  input  logic [DW-1:0]     MRDATA,
  input  logic              MACK,
  input  logic              MSTALL,
  // {D,I} one-hot grant status
  output logic [1:0]        grant
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] d_streak;
  logic          streak_full;
  logic          last_beat;

  assign streak_full = (d_streak == SW'(MAX_D_STREAK));
  // MBURST is the granted master's burst field, so this is only meaningful in GNT_x.
  assign last_beat   = MACK & ((MBURST == 2'b00) | (cnt == CW'(BURST_LEN - 1)));

  assign grant = {state == GNT_D, state == GNT_I};

  // State register; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: D wins in IDLE unless I has waited through a full D streak.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (DREQ && !(IREQ && streak_full)) state_nxt = GNT_D;
        else if (IREQ)                      state_nxt = GNT_I;
      end
      GNT_I:   if (!IREQ || last_beat) state_nxt = IDLE;
      GNT_D:   if (!DREQ || last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter: zero while idle so every grant starts at beat 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else if (MACK)          cnt <= cnt + CW'(1);
  end

  // D streak: counts D grants taken while I waits; updated only on IDLE decisions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_streak <= '0;
    end else if (state == IDLE) begin
      if (state_nxt == GNT_I)                d_streak <= '0;
      else if (state_nxt == GNT_D && IREQ) begin
        if (!streak_full)                    d_streak <= d_streak + SW'(1);
      end
      else if (!IREQ)                        d_streak <= '0;
    end
  end

  // M request mux and response routing; everything parks at 0 without a grant.
  always_comb begin
    MADDR    = '0;
    MBURST   = '0;
    MREQ     = 1'b0;
    MWRB     = 1'b0;
    MWDATA   = '0;
    MBSTROBE = '0;
    IRDATA   = '0;
    DRDATA   = '0;
    IACK     = 1'b0;
    DACK     = 1'b0;
    ISTALL   = IREQ;
    DSTALL   = DREQ;
    case (state)
      GNT_I: begin
        MADDR    = IADDR;
        MBURST   = IBURST;
        MREQ     = IREQ;
        MWRB     = IWRB;
        MWDATA   = IWDATA;
        MBSTROBE = IBSTROBE;
        IRDATA   = MRDATA;
        IACK     = MACK;
        ISTALL   = MSTALL;
      end
      GNT_D: begin
        MADDR    = DADDR;
        MBURST   = DBURST;
        MREQ     = DREQ;
        MWRB     = DWRB;
        MWDATA   = DWDATA;
        MBSTROBE = DBSTROBE;
        DRDATA   = MRDATA;
        DACK     = MACK;
        DSTALL   = MSTALL;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_id_mem_arbiter.sv
// Bench for id_mem_arbiter: directed scenarios plus an ACK scoreboard that
// checks which master each ACK is routed to and the data it carries.
module tb_id_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   IADDR, DADDR, MADDR;
  logic [1:0]      IBURST, DBURST, MBURST;
  logic            IREQ, DREQ, MREQ, IWRB, DWRB, MWRB;
  logic [DW-1:0]   IWDATA, DWDATA, MWDATA, IRDATA, DRDATA, MRDATA;
  logic [DW/8-1:0] IBSTROBE, DBSTROBE, MBSTROBE;
  logic            IACK, DACK, MACK, ISTALL, DSTALL, MSTALL;
  logic [1:0]      grant;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          is_d;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  id_mem_arbiter #(.AW(AW), .DW(DW), .BURST_LEN(4), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .IADDR(IADDR), .IBURST(IBURST), .IREQ(IREQ), .IWRB(IWRB), .IWDATA(IWDATA), .IBSTROBE(IBSTROBE),
    .IRDATA(IRDATA), .IACK(IACK), .ISTALL(ISTALL),
    .DADDR(DADDR), .DBURST(DBURST), .DREQ(DREQ), .DWRB(DWRB), .DWDATA(DWDATA), .DBSTROBE(DBSTROBE),
    .DRDATA(DRDATA), .DACK(DACK), .DSTALL(DSTALL),
    .MADDR(MADDR), .MBURST(MBURST), .MREQ(MREQ), .MWRB(MWRB), .MWDATA(MWDATA), .MBSTROBE(MBSTROBE),
    .MRDATA(MRDATA), .MACK(MACK), .MSTALL(MSTALL),
    .grant(grant)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every routed ACK must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && (IACK === 1'b1 || DACK === 1'b1)) begin
      checks++;
      if (IACK === 1'b1 && DACK === 1'b1) begin
        errors++;
        $display("FAIL sb_both_ack IACK=%b DACK=%b required one", IACK, DACK);
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ack IACK=%b DACK=%b required none", IACK, DACK);
      end else begin
        mon_e = sb_q.pop_front();
        if (DACK !== mon_e.is_d || (DACK ? DRDATA : IRDATA) !== mon_e.data) begin
          errors++;
          $display("FAIL sb_ack is_d=%b data=%h required is_d=%b data=%h",
                   DACK, (DACK ? DRDATA : IRDATA), mon_e.is_d, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    IREQ = 1'b0; DREQ = 1'b0;
    IADDR = 32'h1111_1110; DADDR = 32'h2222_2220;
    IBURST = 2'b01; DBURST = 2'b11; IWRB = 1'b1; DWRB = 1'b1;
    IWDATA = 32'h3333_3333; DWDATA = 32'h4444_4444; IBSTROBE = 4'hF; DBSTROBE = 4'hA;
    MRDATA = 32'h5555_5555; MACK = 1'b1; MSTALL = 1'b1;
    repeat (2) tick();
    checks++;
    if ({grant, MREQ, MADDR, MBURST, MWRB, MWDATA, MBSTROBE} !== '0) begin
      errors++;
      $display("FAIL reset_m_side grant=%b MREQ=%b MADDR=%h MWDATA=%h required all 0", grant, MREQ, MADDR, MWDATA);
    end
    checks++;
    if ({IACK, DACK, ISTALL, DSTALL, IRDATA, DRDATA} !== '0) begin
      errors++;
      $display("FAIL reset_resp IACK=%b DACK=%b ISTALL=%b DSTALL=%b IRDATA=%h DRDATA=%h required all 0",
               IACK, DACK, ISTALL, DSTALL, IRDATA, DRDATA);
    end
    IREQ = 1'b1;
    #1;
    checks++;
    if (ISTALL !== 1'b1 || DSTALL !== 1'b0) begin
      errors++;
      $display("FAIL reset_istall ISTALL=%b DSTALL=%b required 1/0", ISTALL, DSTALL);
    end
    tick();
    checks++;
    if (MREQ !== 1'b0 || grant !== 2'b00 || ISTALL !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold MREQ=%b grant=%b ISTALL=%b required 0/00/1", MREQ, grant, ISTALL);
    end
    IREQ = 1'b0; MACK = 1'b0; MSTALL = 1'b0; MRDATA = '0;
    IBURST = 2'b00; DBURST = 2'b00; IWRB = 1'b0; DWRB = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (grant !== 2'b00 || MREQ !== 1'b0) begin
      errors++;
      $display("FAIL reset_release grant=%b MREQ=%b required 00/0", grant, MREQ);
    end
  endtask

  task automatic test_single_d_read();
    DREQ = 1'b1; DADDR = 32'h100; DBURST = 2'b00; DWRB = 1'b0;
    DWDATA = 32'h0000_1234; DBSTROBE = 4'hF;
    tick();
    checks++;
    if (grant !== 2'b10 || MREQ !== 1'b1 || MADDR !== 32'h100 || MWDATA !== 32'h1234 || MBSTROBE !== 4'hF) begin
      errors++;
      $display("FAIL dread_grant grant=%b MREQ=%b MADDR=%h MWDATA=%h MBSTROBE=%h required 10/1/100/1234/f",
               grant, MREQ, MADDR, MWDATA, MBSTROBE);
    end
    MSTALL = 1'b1;
    #1;
    checks++;
    if (DSTALL !== 1'b1 || DACK !== 1'b0 || ISTALL !== 1'b0) begin
      errors++;
      $display("FAIL dread_stall DSTALL=%b DACK=%b ISTALL=%b required 1/0/0", DSTALL, DACK, ISTALL);
    end
    tick();
    sb_q.push_back('{is_d: 1'b1, data: 32'hDEAD_BEEF});
    MACK = 1'b1; MRDATA = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (DACK !== 1'b1 || DRDATA !== 32'hDEAD_BEEF || IRDATA !== 32'h0 || IACK !== 1'b0) begin
      errors++;
      $display("FAIL dread_ack DACK=%b DRDATA=%h IACK=%b IRDATA=%h required 1/deadbeef/0/0",
               DACK, DRDATA, IACK, IRDATA);
    end
    tick();
    checks++;
    if (grant !== 2'b00 || MREQ !== 1'b0) begin
      errors++;
      $display("FAIL dread_done grant=%b MREQ=%b required 00/0", grant, MREQ);
    end
    MACK = 1'b0; MSTALL = 1'b0; MRDATA = '0; DREQ = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    IREQ = 1'b1; IADDR = 32'h200; IBURST = 2'b00;
    DREQ = 1'b1; DADDR = 32'h300; DBURST = 2'b00;
    tick();
    checks++;
    if (grant !== 2'b10 || MADDR !== 32'h300 || ISTALL !== 1'b1) begin
      errors++;
      $display("FAIL cont_d_first grant=%b MADDR=%h ISTALL=%b required 10/300/1", grant, MADDR, ISTALL);
    end
    sb_q.push_back('{is_d: 1'b1, data: 32'h300 ^ K});
    MACK = 1'b1; MRDATA = MADDR ^ K;
    tick();
    checks++;
    if (grant !== 2'b00 || ISTALL !== 1'b1) begin
      errors++;
      $display("FAIL cont_bubble grant=%b ISTALL=%b required 00/1", grant, ISTALL);
    end
    DREQ = 1'b0; MACK = 1'b0; MRDATA = '0;
    tick();
    checks++;
    if (grant !== 2'b01 || MADDR !== 32'h200 || ISTALL !== 1'b0) begin
      errors++;
      $display("FAIL cont_i_next grant=%b MADDR=%h ISTALL=%b required 01/200/0", grant, MADDR, ISTALL);
    end
    sb_q.push_back('{is_d: 1'b0, data: 32'h200 ^ K});
    MACK = 1'b1; MRDATA = MADDR ^ K;
    tick();
    IREQ = 1'b0; MACK = 1'b0; MRDATA = '0;
    tick();
  endtask

  task automatic test_i_burst_lock();
    IREQ = 1'b1; IADDR = 32'h400; IBURST = 2'b01;
    tick();
    checks++;
    if (grant !== 2'b01 || MBURST !== 2'b01) begin
      errors++;
      $display("FAIL burst_grant grant=%b MBURST=%b required 01/01", grant, MBURST);
    end
    for (int b = 0; b < 4; b++) begin
      tick();
      sb_q.push_back('{is_d: 1'b0, data: 32'h400 ^ K ^ b});
      MACK = 1'b1; MRDATA = MADDR ^ K ^ b;
      #1;
      checks++;
      if (IACK !== 1'b1 || DACK !== 1'b0 || grant !== 2'b01) begin
        errors++;
        $display("FAIL burst_beat%0d IACK=%b DACK=%b grant=%b required 1/0/01", b, IACK, DACK, grant);
      end
      tick();
      checks++;
      if (grant !== ((b < 3) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL burst_lock%0d grant=%b required %b", b, grant, ((b < 3) ? 2'b01 : 2'b00));
      end
      MACK = 1'b0; MRDATA = '0;
      if (b == 0) begin
        DREQ = 1'b1; DADDR = 32'h500; DBURST = 2'b00;
        #1;
        checks++;
        if (DSTALL !== 1'b1 || grant !== 2'b01) begin
          errors++;
          $display("FAIL burst_d_wait DSTALL=%b grant=%b required 1/01", DSTALL, grant);
        end
      end
    end
    IREQ = 1'b0; IBURST = 2'b00;
    tick();
    checks++;
    if (grant !== 2'b10 || MADDR !== 32'h500) begin
      errors++;
      $display("FAIL burst_d_after grant=%b MADDR=%h required 10/500", grant, MADDR);
    end
    sb_q.push_back('{is_d: 1'b1, data: 32'h500 ^ K});
    MACK = 1'b1; MRDATA = MADDR ^ K;
    tick();
    DREQ = 1'b0; MACK = 1'b0; MRDATA = '0;
    tick();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_g;
    IREQ = 1'b1; IADDR = 32'h600; IBURST = 2'b00;
    DREQ = 1'b1; DADDR = 32'h700; DBURST = 2'b00;
    for (int i = 0; i < 10; i++)
      sb_q.push_back('{is_d: (i % 5 != 4), data: ((i % 5 == 4) ? 32'h600 : 32'h700) ^ K});
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_g = (i % 5 == 4) ? 2'b01 : 2'b10;
      checks++;
      if (grant !== exp_g) begin
        errors++;
        $display("FAIL starve_txn%0d grant=%b required %b", i, grant, exp_g);
      end
      MACK = 1'b1; MRDATA = MADDR ^ K;
      tick();
      MACK = 1'b0; MRDATA = '0;
    end
    IREQ = 1'b0; DREQ = 1'b0;
    tick();
  endtask

  task automatic test_reset_midburst();
    DREQ = 1'b1; DADDR = 32'h800; DBURST = 2'b10; DWRB = 1'b1; DWDATA = 32'hCAFE_0001;
    tick();
    checks++;
    if (grant !== 2'b10 || MWRB !== 1'b1 || MBURST !== 2'b10 || MWDATA !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL rstmb_grant grant=%b MWRB=%b MBURST=%b MWDATA=%h required 10/1/10/cafe0001",
               grant, MWRB, MBURST, MWDATA);
    end
    for (int b = 0; b < 2; b++) begin
      sb_q.push_back('{is_d: 1'b1, data: 32'h800 ^ K ^ b});
      MACK = 1'b1; MRDATA = MADDR ^ K ^ b;
      tick();
      MACK = 1'b0; MRDATA = '0;
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (MREQ !== 1'b0 || grant !== 2'b00 || MWDATA !== 32'h0 || DSTALL !== 1'b1) begin
      errors++;
      $display("FAIL rstmb_async MREQ=%b grant=%b MWDATA=%h DSTALL=%b required 0/00/0/1",
               MREQ, grant, MWDATA, DSTALL);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (grant !== 2'b10) begin
      errors++;
      $display("FAIL rstmb_regrant grant=%b required 10", grant);
    end
    for (int b = 0; b < 4; b++) begin
      sb_q.push_back('{is_d: 1'b1, data: 32'h800 ^ K ^ (b + 4)});
      MACK = 1'b1; MRDATA = MADDR ^ K ^ (b + 4);
      tick();
      checks++;
      if (grant !== ((b < 3) ? 2'b10 : 2'b00)) begin
        errors++;
        $display("FAIL rstmb_beat%0d grant=%b required %b", b, grant, ((b < 3) ? 2'b10 : 2'b00));
      end
      MACK = 1'b0; MRDATA = '0;
    end
    DREQ = 1'b0; DWRB = 1'b0; DBURST = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_d_read();
    test_contention();
    test_i_burst_lock();
    test_starvation();
    test_reset_midburst();
    repeat (2) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover pending=%0d required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_mem_arbiter.md
# id_mem_arbiter

Two-master, one-slave bus arbiter that lets the CPU's instruction-side (I) and data-side (D) memory ports share a single external memory port (M). It sits between the core's IADDR/IREQ/… and DADDR/DREQ/… buses and the memory interconnect, and carries the same request/ack/stall/burst protocol on all three sides. It arbitrates with D-priority, a starvation guard for I, and grant locking for the full length of a burst.

## Interface
- AW, 32, address width
- DW, 32, data width; strobe width is DW/8
- BURST_LEN, 4, beats per burst (power of two, ≥2)
- MAX_D_STREAK, 4, consecutive D grants allowed while I waits
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- IADDR/IBURST/IREQ/IWRB/IWDATA/IBSTROBE  in  AW/2/1/1/DW/DW/8  I-master request side
- IRDATA/IACK/ISTALL  out  DW/1/1  I-master response side
- DADDR/DBURST/DREQ/DWRB/DWDATA/DBSTROBE  in  AW/2/1/1/DW/DW/8  D-master request side
- DRDATA/DACK/DSTALL  out  DW/1/1  D-master response side
- MADDR/MBURST/MREQ/MWRB/MWDATA/MBSTROBE  out  AW/2/1/1/DW/DW/8  slave request side
- MRDATA/MACK/MSTALL  in  DW/1/1  slave response side
- grant  out  2  {D,I} one-hot grant status; 00 = idle

## Operation
- Protocol: master holds xREQ and request fields stable until its final ACK. xBURST=00 means one beat; any nonzero value means BURST_LEN beats. Each MACK completes one beat.
- FSM states: IDLE, GNT_I, GNT_D. The state is registered, and grant is decoded directly from it.
- IDLE arbitration is evaluated on the sampled IREQ/DREQ:
  - DREQ wins, unless IREQ is also high and d_streak==MAX_D_STREAK, in which case I wins.
  - If only one master requests, that master is granted.
- d_streak is a saturating counter:
  - increments on entry to GNT_D while IREQ=1;
  - clears on entry to GNT_I;
  - clears in IDLE when IREQ=0.
- In GNT_x, all M request outputs are driven combinationally from master x.
- The beat counter (log2(BURST_LEN) bits) clears on grant entry and increments on each MACK. Last beat = MACK & (MBURST==00 | cnt==BURST_LEN-1).
- The last beat sends the FSM to IDLE. The grant cannot be pre-empted mid-burst.
- If the granted master drops xREQ before its last beat (protocol abort), the FSM goes to IDLE on the next edge.
- Response routing:
  - xACK = (grant==x) & MACK.
  - xRDATA = MRDATA when grant==x, else 0.
  - xSTALL = (grant==x) ? MSTALL : xREQ. A waiting master is held stalled.
- In IDLE, all M outputs are 0 and MREQ=0.

## Timing
- Reset (rst=0, asynchronous) forces state=IDLE, cnt=0, d_streak=0, grant=00. The only non-zero output this can leave is xSTALL=xREQ (an input); every other output goes to 0 immediately, without a clock, and MREQ drops mid-burst.
- Request-to-MREQ latency is 1 cycle: xREQ is sampled in IDLE at edge n, and MREQ=1 after edge n.
- ACK is combinational pass-through with 0 added latency.
- One IDLE bubble cycle follows every transaction.
- Back-to-back single transfers therefore take at least 2 cycles each, plus slave latency.
- Simultaneous last-beat MACK and a new request from the other master: IDLE for one cycle, then the other master is granted.
- A master re-requesting immediately after its last ACK is arbitrated normally in the bubble cycle.
- MSTALL and MACK both high is treated as ACK; MSTALL is passed through only.

## Test plan
- Reset: hold rst=0 with IREQ=DREQ=0 → all outputs 0, grant=00. Then assert IREQ=1 while rst=0 → ISTALL=1, MREQ=0.
- Single D read:
  - DREQ=1, DADDR=0x100, DBURST=00 at edge 0 → grant=10 and MADDR=0x100 after edge 0.
  - MACK=1, MRDATA=0xDEADBEEF in cycle 2 → DACK=1 and DRDATA=0xDEADBEEF in that cycle, grant=00 after edge 2.
- Contention: IREQ and DREQ rise together → D granted first with ISTALL=1 throughout; I is granted after 1 idle cycle.
- I burst lock:
  - IBURST=01 with 4 MACKs spaced 2 cycles apart, DREQ rising after the 1st ACK → grant stays 01 until the 4th MACK.
  - DACK stays 0 during the burst; D is granted after the bubble.
- Starvation: DREQ held high across 5 single transfers while IREQ=1 → grants D,D,D,D,I; d_streak clears after the I grant.
- Reset mid-burst: assert rst=0 between the 2nd and 3rd beats of a D burst → MREQ=0 and grant=00 immediately. After release, a new DREQ restarts with cnt=0 and needs 4 full beats.
